// File: rtl/pc_predict_unit.sv
// Registered fetch PC with a direct-mapped BTB (2-bit direction counters) and
// execute-stage branch resolution that redirects the PC on a mispredict.
module pc_predict_unit #(
   parameter int unsigned      WIDTH       = 64,
   parameter int unsigned      DEPTH       = 16,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned      INSTR_BYTES = 4
) (
   input  logic             CLK,
   input  logic             resetl,
   input  logic             Stall,
   output logic [WIDTH-1:0] CurrentPC,
   output logic             PredTaken,
   output logic [WIDTH-1:0] PredTarget,
   input  logic             ExValid,
   input  logic [WIDTH-1:0] ExPC,
   input  logic             ExBranch,
   input  logic             ExInvert,
   input  logic             ExUncondbranch,
   input  logic             ExRegBranch,
   input  logic             ExZero,
   input  logic [WIDTH-1:0] ExSignExtImm,
   input  logic [WIDTH-1:0] ExRegTarget,
   input  logic             ExPredTaken,
   input  logic [WIDTH-1:0] ExPredTarget,
   output logic             Flush
);

   localparam int unsigned      IDX  = $clog2(DEPTH);
   localparam int unsigned      TW   = WIDTH - IDX - 2;
   localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

   logic             btb_valid  [DEPTH];
   logic             btb_uncond [DEPTH];
   logic [1:0]       btb_ctr    [DEPTH];
   logic [TW-1:0]    btb_tag    [DEPTH];
   logic [WIDTH-1:0] btb_target [DEPTH];

   logic [IDX-1:0]   f_idx, e_idx;
   logic [TW-1:0]    f_tag, e_tag;
   logic             f_hit, e_hit;
   logic             resolve, taken;
   logic [WIDTH-1:0] actual;
   logic [1:0]       ctr_next;

   always_comb begin
      f_idx      = CurrentPC[IDX+1:2];
      f_tag      = CurrentPC[WIDTH-1:IDX+2];
      f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      PredTaken  = f_hit && (btb_uncond[f_idx] || btb_ctr[f_idx][1]);
      PredTarget = PredTaken ? btb_target[f_idx] : CurrentPC + STEP;
   end

   always_comb begin
      e_idx   = ExPC[IDX+1:2];
      e_tag   = ExPC[WIDTH-1:IDX+2];
      e_hit   = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
      resolve = ExValid && (ExBranch || ExUncondbranch || ExRegBranch);
      taken   = resolve && (ExUncondbranch || ExRegBranch || (ExBranch && (ExZero ^ ExInvert)));
      if (taken)
         actual = ExRegBranch ? ExRegTarget : ExPC + ExSignExtImm;
      else
         actual = ExPC + STEP;
      // Non-branch in EX carrying a taken prediction came from a stale alias.
      if (resolve)
         Flush = (ExPredTaken != taken) || (taken && (ExPredTarget != actual));
      else
         Flush = ExValid && ExPredTaken;
      if (taken)
         ctr_next = (btb_ctr[e_idx] == 2'b11) ? 2'b11 : btb_ctr[e_idx] + 2'b01;
      else
         ctr_next = (btb_ctr[e_idx] == 2'b00) ? 2'b00 : btb_ctr[e_idx] - 2'b01;
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl)
         CurrentPC <= RESET_PC;
      else if (Flush)
         CurrentPC <= actual;
      else if (!Stall)
         CurrentPC <= PredTarget;
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_uncond[i] <= 1'b0;
            btb_ctr[i]    <= 2'b01;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
         end
      end else if (resolve) begin
         if (e_hit) begin
            btb_ctr[e_idx]    <= ctr_next;
            btb_uncond[e_idx] <= ExUncondbranch || ExRegBranch;
            if (taken)
               btb_target[e_idx] <= actual;
         end else if (taken) begin
            btb_valid[e_idx]  <= 1'b1;
            btb_tag[e_idx]    <= e_tag;
            btb_target[e_idx] <= actual;
            btb_ctr[e_idx]    <= 2'b10;
            btb_uncond[e_idx] <= ExUncondbranch || ExRegBranch;
         end
      end
   end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios plus random EX traffic checked
// against a table-based model of the predictor and PC sequencing.
module tb_pc_predict_unit;

   logic        CLK = 1'b0;
   logic        resetl;
   logic        Stall;
   logic [63:0] CurrentPC;
   logic        PredTaken;
   logic [63:0] PredTarget;
   logic        ExValid, ExBranch, ExInvert, ExUncondbranch, ExRegBranch, ExZero;
   logic        ExPredTaken;
   logic [63:0] ExPC, ExSignExtImm, ExRegTarget, ExPredTarget;
   logic        Flush;

   int errors = 0;
   int checks = 0;

   pc_predict_unit #(
      .WIDTH(64), .DEPTH(16), .RESET_PC(64'h400), .INSTR_BYTES(4)
   ) dut (
      .CLK(CLK), .resetl(resetl), .Stall(Stall),
      .CurrentPC(CurrentPC), .PredTaken(PredTaken), .PredTarget(PredTarget),
      .ExValid(ExValid), .ExPC(ExPC), .ExBranch(ExBranch), .ExInvert(ExInvert),
      .ExUncondbranch(ExUncondbranch), .ExRegBranch(ExRegBranch), .ExZero(ExZero),
      .ExSignExtImm(ExSignExtImm), .ExRegTarget(ExRegTarget),
      .ExPredTaken(ExPredTaken), .ExPredTarget(ExPredTarget), .Flush(Flush)
   );

   always #5 CLK = ~CLK;

   // Reference model: BTB as plain tables, counters as integers 0..3.
   bit          m_valid  [16];
   bit          m_uncond [16];
   int          m_ctr    [16];
   logic [63:0] m_tag    [16];
   logic [63:0] m_target [16];
   logic [63:0] m_pc;

   function automatic int ix(logic [63:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_hit(logic [63:0] pc);
      return m_valid[ix(pc)] && (m_tag[ix(pc)] == pc / 64);
   endfunction

   function automatic bit m_pred_taken(logic [63:0] pc);
      return m_hit(pc) && (m_uncond[ix(pc)] || m_ctr[ix(pc)] >= 2);
   endfunction

   function automatic logic [63:0] m_pred_target(logic [63:0] pc);
      return m_pred_taken(pc) ? m_target[ix(pc)] : pc + 64'd4;
   endfunction

   function automatic bit m_is_br();
      return ExValid && (ExBranch || ExUncondbranch || ExRegBranch);
   endfunction

   function automatic bit m_taken();
      if (!m_is_br()) return 1'b0;
      if (ExUncondbranch || ExRegBranch) return 1'b1;
      return ExBranch && (ExInvert ? !ExZero : ExZero);
   endfunction

   function automatic logic [63:0] m_actual();
      if (!m_taken()) return ExPC + 64'd4;
      return ExRegBranch ? ExRegTarget : ExPC + ExSignExtImm;
   endfunction

   function automatic bit m_flush();
      if (!m_is_br()) return ExValid && ExPredTaken;
      if (ExPredTaken != m_taken()) return 1'b1;
      return m_taken() && (ExPredTarget != m_actual());
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_uncond[i] = 0; m_ctr[i] = 1;
         m_tag[i] = '0; m_target[i] = '0;
      end
      m_pc = 64'h400;
   endtask

   task automatic clear_ex();
      ExValid = 0; ExBranch = 0; ExInvert = 0; ExUncondbranch = 0; ExRegBranch = 0;
      ExZero = 0; ExPredTaken = 0; ExPC = '0; ExSignExtImm = '0; ExRegTarget = '0;
      ExPredTarget = '0; Stall = 0;
   endtask

   task automatic settle();
      #1;
   endtask

   // Advance one clock; the model computes next state from pre-edge values.
   task automatic tick();
      logic [63:0] npc;
      int i;
      if (m_flush()) npc = m_actual();
      else if (Stall) npc = m_pc;
      else npc = m_pred_target(m_pc);
      if (m_is_br()) begin
         i = ix(ExPC);
         if (m_hit(ExPC)) begin
            m_ctr[i] = m_taken() ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                 : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (m_taken()) m_target[i] = m_actual();
            m_uncond[i] = ExUncondbranch || ExRegBranch;
         end else if (m_taken()) begin
            m_valid[i] = 1; m_tag[i] = ExPC / 64; m_target[i] = m_actual();
            m_ctr[i] = 2; m_uncond[i] = ExUncondbranch || ExRegBranch;
         end
      end
      @(posedge CLK);
      m_pc = npc;
      #1;
      clear_ex();
   endtask

   // Steer fetch to pc via a stale-alias flush (no BTB write).
   task automatic redirect_to(logic [63:0] pc);
      clear_ex();
      ExValid = 1; ExPC = pc - 64'd4; ExPredTaken = 1;
      tick();
   endtask

   task automatic test_reset();
      clear_ex();
      resetl = 0;
      model_reset();
      #12;
      checks++; if (CurrentPC !== 64'h400) begin errors++; $display("FAIL reset_pc: got %h expected %h", CurrentPC, 64'h400); end
      checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL reset_predtaken: got %b expected 0", PredTaken); end
      checks++; if (PredTarget !== 64'h404) begin errors++; $display("FAIL reset_predtarget: got %h expected %h", PredTarget, 64'h404); end
      checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", Flush); end
      @(negedge CLK);
      resetl = 1;
      tick();
      checks++; if (CurrentPC !== 64'h404) begin errors++; $display("FAIL seq_pc1: got %h expected %h", CurrentPC, 64'h404); end
      tick();
      checks++; if (CurrentPC !== 64'h408) begin errors++; $display("FAIL seq_pc2: got %h expected %h", CurrentPC, 64'h408); end
      checks++; if (PredTaken !== 1'b0 || Flush !== 1'b0) begin errors++; $display("FAIL seq_nopred: got %b/%b expected 0/0", PredTaken, Flush); end
   endtask

   task automatic test_uncond_branch();
      ExValid = 1; ExPC = 64'h408; ExUncondbranch = 1; ExSignExtImm = 64'h20; ExPredTaken = 0;
      settle();
      checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL b_flush: got %b expected 1", Flush); end
      tick();
      checks++; if (CurrentPC !== 64'h428) begin errors++; $display("FAIL b_redirect: got %h expected %h", CurrentPC, 64'h428); end
      redirect_to(64'h408);
      checks++; if (CurrentPC !== 64'h408) begin errors++; $display("FAIL b_refetch_pc: got %h expected %h", CurrentPC, 64'h408); end
      checks++; if (PredTaken !== 1'b1) begin errors++; $display("FAIL b_predtaken: got %b expected 1", PredTaken); end
      checks++; if (PredTarget !== 64'h428) begin errors++; $display("FAIL b_predtarget: got %h expected %h", PredTarget, 64'h428); end
   endtask

   task automatic test_cbz_counter();
      bit          zero_seq [5] = '{1, 1, 0, 0, 0};
      bit          pred_seq [5] = '{1, 1, 1, 0, 0};
      logic [63:0] tgt;
      for (int k = 0; k < 5; k++) begin
         ExValid = 1; ExPC = 64'h500; ExBranch = 1; ExZero = zero_seq[k];
         ExSignExtImm = 64'h40;
         ExPredTaken = m_pred_taken(64'h500); ExPredTarget = m_pred_target(64'h500);
         settle();
         checks++; if (Flush !== m_flush()) begin errors++; $display("FAIL cbz_flush[%0d]: got %b expected %b", k, Flush, m_flush()); end
         tick();
         redirect_to(64'h500);
         tgt = pred_seq[k] ? 64'h540 : 64'h504;
         checks++; if (PredTaken !== pred_seq[k]) begin errors++; $display("FAIL cbz_pred[%0d]: got %b expected %b", k, PredTaken, pred_seq[k]); end
         checks++; if (PredTarget !== tgt) begin errors++; $display("FAIL cbz_target[%0d]: got %h expected %h", k, PredTarget, tgt); end
      end
   endtask

   task automatic test_cbnz();
      ExValid = 1; ExPC = 64'h600; ExBranch = 1; ExInvert = 1; ExZero = 0; ExSignExtImm = 64'h80;
      settle();
      checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL cbnz_taken_flush: got %b expected 1", Flush); end
      tick();
      checks++; if (CurrentPC !== 64'h680) begin errors++; $display("FAIL cbnz_taken_pc: got %h expected %h", CurrentPC, 64'h680); end
      ExValid = 1; ExPC = 64'h6C0; ExBranch = 1; ExInvert = 1; ExZero = 1; ExSignExtImm = 64'h80;
      settle();
      checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL cbnz_nt_flush: got %b expected 0", Flush); end
      tick();
      redirect_to(64'h6C0);
      checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL cbnz_no_alloc: got %b expected 0", PredTaken); end
   endtask

   task automatic test_reg_branch();
      ExValid = 1; ExPC = 64'h800; ExRegBranch = 1; ExRegTarget = 64'h2000;
      tick();
      ExValid = 1; ExPC = 64'h800; ExRegBranch = 1; ExRegTarget = 64'h1000;
      ExPredTaken = 1; ExPredTarget = 64'h2000;
      settle();
      checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %b expected 1", Flush); end
      tick();
      checks++; if (CurrentPC !== 64'h1000) begin errors++; $display("FAIL br_pc: got %h expected %h", CurrentPC, 64'h1000); end
      redirect_to(64'h800);
      checks++; if (PredTarget !== 64'h1000) begin errors++; $display("FAIL br_target_update: got %h expected %h", PredTarget, 64'h1000); end
   endtask

   task automatic test_stall();
      logic [63:0] held;
      held = CurrentPC;
      for (int k = 0; k < 3; k++) begin
         Stall = 1;
         tick();
         checks++; if (CurrentPC !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, CurrentPC, held); end
      end
      Stall = 1; ExValid = 1; ExPC = 64'h900; ExUncondbranch = 1; ExSignExtImm = 64'h100;
      settle();
      checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL stall_flush: got %b expected 1", Flush); end
      tick();
      checks++; if (CurrentPC !== 64'hA00) begin errors++; $display("FAIL stall_redirect: got %h expected %h", CurrentPC, 64'hA00); end
   endtask

   task automatic test_random();
      int kind;
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 5);
         ExValid = ($urandom_range(0, 7) != 0);
         ExPC = 64'h1000 + 64'd4 * 64'($urandom_range(0, 47));
         ExBranch = (kind == 1); ExUncondbranch = (kind == 2); ExRegBranch = (kind == 3);
         ExInvert = $urandom_range(0, 1); ExZero = $urandom_range(0, 1);
         ExSignExtImm = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom}
                                                   : 64'd4 * 64'($urandom_range(0, 31)) - 64'h40;
         ExRegTarget = 64'h1000 + 64'd4 * 64'($urandom_range(0, 47));
         if ($urandom_range(0, 1) == 1) begin
            ExPredTaken = m_pred_taken(ExPC); ExPredTarget = m_pred_target(ExPC);
         end else begin
            ExPredTaken = $urandom_range(0, 1); ExPredTarget = ExRegTarget;
         end
         Stall = ($urandom_range(0, 4) == 0);
         settle();
         checks++; if (CurrentPC !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, CurrentPC, m_pc); end
         checks++; if (PredTaken !== m_pred_taken(m_pc)) begin errors++; $display("FAIL rnd_predtaken[%0d]: got %b expected %b", n, PredTaken, m_pred_taken(m_pc)); end
         checks++; if (PredTarget !== m_pred_target(m_pc)) begin errors++; $display("FAIL rnd_predtarget[%0d]: got %h expected %h", n, PredTarget, m_pred_target(m_pc)); end
         checks++; if (Flush !== m_flush()) begin errors++; $display("FAIL rnd_flush[%0d]: got %b expected %b", n, Flush, m_flush()); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] probe [4] = '{64'h408, 64'h500, 64'h800, 64'h1010};
      ExValid = 1; ExPC = 64'h408; ExUncondbranch = 1; ExSignExtImm = 64'h20;
      #2;
      resetl = 0;
      #1;
      model_reset();
      checks++; if (CurrentPC !== 64'h400) begin errors++; $display("FAIL midreset_pc: got %h expected %h", CurrentPC, 64'h400); end
      checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL midreset_flush_comb: got %b expected 1", Flush); end
      clear_ex();
      @(negedge CLK);
      resetl = 1;
      tick();
      checks++; if (CurrentPC !== 64'h404) begin errors++; $display("FAIL midreset_seq: got %h expected %h", CurrentPC, 64'h404); end
      for (int k = 0; k < 4; k++) begin
         redirect_to(probe[k]);
         checks++; if (PredTaken !== 1'b0) begin errors++; $display("FAIL midreset_miss[%0d]: got %b expected 0", k, PredTaken); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_uncond_branch();
      test_cbz_counter();
      test_cbnz();
      test_reg_branch();
      test_stall();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
